// File: rtl/icache_direct_if.sv
// Fetch-side and memory-side handshake bundle for icache_direct.
// The slave modport is the cache. The master modport is the fetch unit and memory controller that surround it.
interface icache_direct_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_busy;
    logic        if_valid;
    logic [31:0] if_ins;
    logic [31:0] if_pc;
    logic        iCache_need;
    logic [31:0] ins_addr;
    logic        ins_ready;
    logic [31:0] ins;

    modport slave (
        input  if_req, if_addr, ins_ready, ins,
        output if_busy, if_valid, if_ins, if_pc, iCache_need, ins_addr
    );

    modport master (
        output if_req, if_addr, ins_ready, ins,
        input  if_busy, if_valid, if_ins, if_pc, iCache_need, ins_addr
    );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-line instruction cache: hits answer the cycle after the request, and misses fetch through the memory controller.
// Optional hit/miss counters are enabled with `define ICACHE_STATS_EN.
module icache_direct #(
    parameter int INDEX_BITS = 6
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            rdy_in,
    input  logic            flush_in,
    icache_direct_if.slave  bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]     hit_cnt,
    output logic [31:0]     miss_cnt
`endif
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 30 - INDEX_BITS;

    typedef enum logic {
        S_IDLE,
        S_MISS
    } state_t;

    state_t                r_state;
    logic [LINES-1:0]      r_lineValid;
    logic [TAG_BITS-1:0]   r_tagArr  [LINES];
    logic [31:0]           r_dataArr [LINES];

    logic                  r_busy;
    logic                  r_ifValid;
    logic [31:0]           r_ifIns;
    logic [31:0]           r_ifPc;
    logic                  r_need;
    logic [31:0]           r_insAddr;
    logic                  r_discard;
    logic [31:0]           r_missPc;
    logic [INDEX_BITS-1:0] r_missIdx;
    logic [TAG_BITS-1:0]   r_missTag;

    logic [INDEX_BITS-1:0] w_idx;
    logic [TAG_BITS-1:0]   w_tag;
    logic                  w_hit;
    logic                  w_fill;

    assign w_idx  = bus.if_addr[INDEX_BITS+1:2];
    assign w_tag  = bus.if_addr[31:INDEX_BITS+2];
    assign w_hit  = r_lineValid[w_idx] && (r_tagArr[w_idx] == w_tag);
    assign w_fill = rdy_in && (r_state == S_MISS) && bus.ins_ready;

    assign bus.if_busy     = r_busy;
    assign bus.if_valid    = r_ifValid;
    assign bus.if_ins      = r_ifIns;
    assign bus.if_pc       = r_ifPc;
    assign bus.iCache_need = r_need;
    assign bus.ins_addr    = r_insAddr;

    // Tag and data arrays carry no reset. Their contents are only trusted once the matching valid bit is set.
    always_ff @(posedge clk_in) begin
        if (w_fill) begin
            r_tagArr[r_missIdx]  <= r_missTag;
            r_dataArr[r_missIdx] <= bus.ins;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] r_hitCnt;
    logic [31:0] r_missCnt;

    assign hit_cnt  = r_hitCnt;
    assign miss_cnt = r_missCnt;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_hitCnt  <= '0;
            r_missCnt <= '0;
        end else if (rdy_in && r_state == S_IDLE && !flush_in && bus.if_req) begin
            if (w_hit) r_hitCnt  <= r_hitCnt + 32'd1;
            else       r_missCnt <= r_missCnt + 32'd1;
        end
    end
`endif

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state     <= S_IDLE;
            r_lineValid <= '0;
            r_busy      <= 1'b0;
            r_ifValid   <= 1'b0;
            r_ifIns     <= '0;
            r_ifPc      <= '0;
            r_need      <= 1'b0;
            r_insAddr   <= '0;
            r_discard   <= 1'b0;
            r_missPc    <= '0;
            r_missIdx   <= '0;
            r_missTag   <= '0;
        end else if (rdy_in) begin
            r_ifValid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!flush_in && bus.if_req) begin
                        if (w_hit) begin
                            r_ifValid <= 1'b1;
                            r_ifIns   <= r_dataArr[w_idx];
                            r_ifPc    <= bus.if_addr;
                        end else begin
                            r_state   <= S_MISS;
                            r_need    <= 1'b1;
                            r_insAddr <= {bus.if_addr[31:2], 2'b00};
                            r_busy    <= 1'b1;
                            r_missPc  <= bus.if_addr;
                            r_missIdx <= w_idx;
                            r_missTag <= w_tag;
                        end
                    end
                end
                S_MISS: begin
                    // The memory transaction cannot be aborted, so a flush only suppresses the eventual response.
                    if (bus.ins_ready) begin
                        r_lineValid[r_missIdx] <= 1'b1;
                        r_need    <= 1'b0;
                        r_insAddr <= '0;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                        r_discard <= 1'b0;
                        if (!r_discard && !flush_in) begin
                            r_ifValid <= 1'b1;
                            r_ifIns   <= bus.ins;
                            r_ifPc    <= r_missPc;
                        end
                    end else if (flush_in) begin
                        r_discard <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_direct.sv
// Directed self-checking bench for icache_direct.
// It covers hit/miss, conflict eviction, flush handling, rdy_in freeze, async reset and the optional statistics counters.
module tb_icache_direct;

    logic clk_in;
    logic rst_in;
    logic rdy_in;
    logic flush_in;
    int   testsRun;
    int   testsFailed;

    icache_direct_if bus();

`ifdef ICACHE_STATS_EN
    logic [31:0] hitCnt;
    logic [31:0] missCnt;
`endif

    icache_direct #(.INDEX_BITS(6)) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rdy_in   (rdy_in),
        .flush_in (flush_in),
        .bus      (bus.slave)
`ifdef ICACHE_STATS_EN
        ,
        .hit_cnt  (hitCnt),
        .miss_cnt (missCnt)
`endif
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Inputs change just after a falling edge. Outputs are checked on the next falling edge, half a cycle after the DUT updates.
    task automatic issue(input logic [31:0] addr);
        bus.if_req  = 1'b1;
        bus.if_addr = addr;
        @(negedge clk_in);
        bus.if_req  = 1'b0;
    endtask

    task automatic respond(input logic [31:0] data, input logic fl);
        bus.ins_ready = 1'b1;
        bus.ins       = data;
        flush_in      = fl;
        @(negedge clk_in);
        bus.ins_ready = 1'b0;
        flush_in      = 1'b0;
    endtask

    task automatic test_reset;
        rst_in        = 1'b0;
        rdy_in        = 1'b1;
        flush_in      = 1'b0;
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.ins_ready = 1'b0;
        bus.ins       = '0;
        repeat (2) @(negedge clk_in);
        testsRun++;
        if (bus.iCache_need !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_need: got %h expected 0", bus.iCache_need); end
        testsRun++;
        if (bus.if_valid !== 1'b0 || bus.if_busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_valid_busy: got %b%b expected 00", bus.if_valid, bus.if_busy); end
        testsRun++;
        if (bus.if_ins !== 32'h0 || bus.if_pc !== 32'h0 || bus.ins_addr !== 32'h0) begin
            testsFailed++; $display("[TB] FAIL reset_data: got ins=%h pc=%h addr=%h expected zeros", bus.if_ins, bus.if_pc, bus.ins_addr);
        end
        rst_in = 1'b1;
        @(negedge clk_in);
    endtask

    task automatic test_miss_fill;
        issue(32'h0000_0010);
        testsRun++;
        if (bus.iCache_need !== 1'b1 || bus.ins_addr !== 32'h10 || bus.if_busy !== 1'b1) begin
            testsFailed++; $display("[TB] FAIL miss_request: got need=%b addr=%h busy=%b expected 1/00000010/1", bus.iCache_need, bus.ins_addr, bus.if_busy);
        end
        repeat (2) @(negedge clk_in);
        testsRun++;
        if (bus.iCache_need !== 1'b1 || bus.if_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL miss_hold: got need=%b valid=%b expected 1/0", bus.iCache_need, bus.if_valid); end
        respond(32'h00A0_0093, 1'b0);
        testsRun++;
        if (bus.if_valid !== 1'b1 || bus.if_ins !== 32'h00A0_0093 || bus.if_pc !== 32'h10) begin
            testsFailed++; $display("[TB] FAIL miss_response: got valid=%b ins=%h pc=%h expected 1/00a00093/00000010", bus.if_valid, bus.if_ins, bus.if_pc);
        end
        testsRun++;
        if (bus.iCache_need !== 1'b0 || bus.if_busy !== 1'b0 || bus.ins_addr !== 32'h0) begin
            testsFailed++; $display("[TB] FAIL miss_release: got need=%b busy=%b addr=%h expected 0/0/0", bus.iCache_need, bus.if_busy, bus.ins_addr);
        end
        @(negedge clk_in);
        testsRun++;
        if (bus.if_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL valid_pulse: got %b expected 0", bus.if_valid); end
        issue(32'h0000_0010);
        testsRun++;
        if (bus.if_valid !== 1'b1 || bus.if_ins !== 32'h00A0_0093 || bus.iCache_need !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL hit_after_fill: got valid=%b ins=%h need=%b expected 1/00a00093/0", bus.if_valid, bus.if_ins, bus.iCache_need);
        end
    endtask

    task automatic test_conflict;
        issue(32'h0000_0110);
        testsRun++;
        if (bus.iCache_need !== 1'b1 || bus.ins_addr !== 32'h110) begin
            testsFailed++; $display("[TB] FAIL conflict_miss: got need=%b addr=%h expected 1/00000110", bus.iCache_need, bus.ins_addr);
        end
        respond(32'h1111_1111, 1'b0);
        testsRun++;
        if (bus.if_valid !== 1'b1 || bus.if_ins !== 32'h1111_1111 || bus.if_pc !== 32'h110) begin
            testsFailed++; $display("[TB] FAIL conflict_resp: got valid=%b ins=%h pc=%h expected 1/11111111/00000110", bus.if_valid, bus.if_ins, bus.if_pc);
        end
        issue(32'h0000_0010);
        testsRun++;
        if (bus.iCache_need !== 1'b1 || bus.if_valid !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL evicted_refetch: got need=%b valid=%b expected 1/0", bus.iCache_need, bus.if_valid);
        end
        respond(32'h00A0_0093, 1'b0);
    endtask

    task automatic test_flush_miss;
        issue(32'h0000_0020);
        flush_in = 1'b1;
        @(negedge clk_in);
        flush_in = 1'b0;
        @(negedge clk_in);
        testsRun++;
        if (bus.iCache_need !== 1'b1 || bus.if_busy !== 1'b1) begin
            testsFailed++; $display("[TB] FAIL flush_keeps_need: got need=%b busy=%b expected 1/1", bus.iCache_need, bus.if_busy);
        end
        respond(32'h2222_2222, 1'b0);
        testsRun++;
        if (bus.if_valid !== 1'b0 || bus.if_busy !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL flush_discard: got valid=%b busy=%b expected 0/0", bus.if_valid, bus.if_busy);
        end
        issue(32'h0000_0020);
        testsRun++;
        if (bus.if_valid !== 1'b1 || bus.if_ins !== 32'h2222_2222 || bus.iCache_need !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL flushed_line_hit: got valid=%b ins=%h need=%b expected 1/22222222/0", bus.if_valid, bus.if_ins, bus.iCache_need);
        end
        issue(32'h0000_0040);
        respond(32'h4444_4444, 1'b0);
        testsRun++;
        if (bus.if_valid !== 1'b1 || bus.if_ins !== 32'h4444_4444) begin
            testsFailed++; $display("[TB] FAIL discard_cleared: got valid=%b ins=%h expected 1/44444444", bus.if_valid, bus.if_ins);
        end
    endtask

    task automatic test_flush_same_cycle;
        issue(32'h0000_0030);
        respond(32'h3333_3333, 1'b1);
        testsRun++;
        if (bus.if_valid !== 1'b0 || bus.iCache_need !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL flush_with_ready: got valid=%b need=%b expected 0/0", bus.if_valid, bus.iCache_need);
        end
        issue(32'h0000_0030);
        testsRun++;
        if (bus.if_valid !== 1'b1 || bus.if_ins !== 32'h3333_3333 || bus.if_pc !== 32'h30) begin
            testsFailed++; $display("[TB] FAIL flush_ready_filled: got valid=%b ins=%h pc=%h expected 1/33333333/00000030", bus.if_valid, bus.if_ins, bus.if_pc);
        end
    endtask

    task automatic test_flush_idle;
        flush_in = 1'b1;
        issue(32'h0000_0050);
        testsRun++;
        if (bus.iCache_need !== 1'b0 || bus.if_busy !== 1'b0 || bus.if_valid !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL flush_idle_miss: got need=%b busy=%b valid=%b expected 0/0/0", bus.iCache_need, bus.if_busy, bus.if_valid);
        end
        issue(32'h0000_0020);
        testsRun++;
        if (bus.if_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL flush_idle_hit: got valid=%b expected 0", bus.if_valid); end
        flush_in = 1'b0;
    endtask

    task automatic test_rdy_freeze;
        issue(32'h0000_0060);
        rdy_in        = 1'b0;
        bus.ins_ready = 1'b1;
        bus.ins       = 32'h6666_6666;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            testsRun++;
            if (bus.iCache_need !== 1'b1 || bus.if_valid !== 1'b0) begin
                testsFailed++; $display("[TB] FAIL freeze_hold_%0d: got need=%b valid=%b expected 1/0", i, bus.iCache_need, bus.if_valid);
            end
        end
        rdy_in = 1'b1;
        @(negedge clk_in);
        testsRun++;
        if (bus.if_valid !== 1'b1 || bus.if_ins !== 32'h6666_6666 || bus.if_pc !== 32'h60) begin
            testsFailed++; $display("[TB] FAIL freeze_resume: got valid=%b ins=%h pc=%h expected 1/66666666/00000060", bus.if_valid, bus.if_ins, bus.if_pc);
        end
        @(negedge clk_in);
        testsRun++;
        if (bus.if_valid !== 1'b0 || bus.iCache_need !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL freeze_single: got valid=%b need=%b expected 0/0", bus.if_valid, bus.iCache_need);
        end
        bus.ins_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [31:0] addrs [3];
        logic [31:0] datas [3];
        addrs = '{32'h20, 32'h30, 32'h60};
        datas = '{32'h2222_2222, 32'h3333_3333, 32'h6666_6666};
        bus.if_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.if_addr = addrs[i];
            @(negedge clk_in);
            testsRun++;
            if (bus.if_valid !== 1'b1 || bus.if_ins !== datas[i] || bus.if_pc !== addrs[i]) begin
                testsFailed++; $display("[TB] FAIL b2b_hit_%0d: got valid=%b ins=%h pc=%h expected 1/%h/%h", i, bus.if_valid, bus.if_ins, bus.if_pc, datas[i], addrs[i]);
            end
        end
        bus.if_req = 1'b0;
        @(negedge clk_in);
    endtask

    task automatic test_async_reset;
        issue(32'h0000_0070);
        #2;
        rst_in = 1'b0;
        #1;
        testsRun++;
        if (bus.iCache_need !== 1'b0 || bus.if_busy !== 1'b0 || bus.ins_addr !== 32'h0) begin
            testsFailed++; $display("[TB] FAIL async_reset: got need=%b busy=%b addr=%h expected 0/0/0", bus.iCache_need, bus.if_busy, bus.ins_addr);
        end
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        issue(32'h0000_0020);
        testsRun++;
        if (bus.iCache_need !== 1'b1 || bus.if_valid !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL reset_invalidates: got need=%b valid=%b expected 1/0", bus.iCache_need, bus.if_valid);
        end
        respond(32'h2222_2222, 1'b0);
    endtask

`ifdef ICACHE_STATS_EN
    task automatic test_stats;
        rst_in = 1'b0;
        @(negedge clk_in);
        testsRun++;
        if (hitCnt !== 32'd0 || missCnt !== 32'd0) begin testsFailed++; $display("[TB] FAIL stats_reset: got %0d/%0d expected 0/0", hitCnt, missCnt); end
        rst_in = 1'b1;
        @(negedge clk_in);
        issue(32'h0000_0010);
        respond(32'h00A0_0093, 1'b0);
        issue(32'h0000_0020);
        respond(32'h2222_2222, 1'b0);
        issue(32'h0000_0010);
        issue(32'h0000_0020);
        issue(32'h0000_0010);
        flush_in = 1'b1;
        issue(32'h0000_0010);
        flush_in = 1'b0;
        testsRun++;
        if (hitCnt !== 32'd3 || missCnt !== 32'd2) begin testsFailed++; $display("[TB] FAIL stats_counts: got %0d/%0d expected 3/2", hitCnt, missCnt); end
    endtask
`endif

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        test_reset();
        test_miss_fill();
        test_conflict();
        test_flush_miss();
        test_flush_same_cycle();
        test_flush_idle();
        test_rdy_freeze();
        test_back_to_back();
        test_async_reset();
`ifdef ICACHE_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, one-word-per-line instruction cache between the instruction fetch unit and the memory controller's instruction port.
- Hits return an instruction one cycle after the request.
- Misses issue a 4-byte fetch through the memory controller's iCache_need/ins_addr/ins_ready/ins handshake, fill the line, then respond.
- Fetch-side flush cancels an outstanding response without aborting the memory transaction.

Parameters:
INDEX_BITS, 6, log2 of line count (64 lines); index = addr[INDEX_BITS+1:2], tag = addr[31:INDEX_BITS+2]

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset, asynchronous, active-low
rdy_in  input  1  global ready; low freezes all state
flush_in  input  1  fetch redirect; cancel pending response
if_req  input  1  fetch request, sampled when if_busy=0
if_addr  input  32  fetch PC; bits [1:0] ignored
if_busy  output  1  high while a miss is outstanding; requests ignored
if_valid  output  1  one-cycle pulse: if_ins valid
if_ins  output  32  returned instruction
if_pc  output  32  PC belonging to if_ins
iCache_need  output  1  fetch request to memory controller
ins_addr  output  32  word-aligned fetch address to memory controller
ins_ready  input  1  memory controller fetch-done pulse
ins  input  32  fetched word, little-endian assembled

Behaviour:
- Reset (rst_in=0, async): all valid bits cleared; state IDLE; if_busy=0, if_valid=0, if_ins=0, if_pc=0, iCache_need=0, ins_addr=0, discard flag=0. Tag/data arrays need no reset.
- rdy_in=0: no register updates. Outputs hold. A held ins_ready is not consumed twice.
- Storage: valid[2^INDEX_BITS], tag[2^INDEX_BITS] of (30-INDEX_BITS) bits, data[2^INDEX_BITS] of 32 bits. Lookup is combinational on if_addr; all outputs are registered.
- IDLE:
  - if_valid defaults to 0 every cycle unless set below.
  - flush_in=1: request ignored (flush wins over simultaneous if_req).
  - if_req=1 and hit: next cycle if_valid=1, if_ins=data[idx], if_pc=if_addr. Back-to-back hits give one per cycle.
  - if_req=1 and miss: next cycle state MISS, iCache_need=1, ins_addr={if_addr[31:2],2'b00}, if_busy=1. Latch pc and index/tag.
- MISS:
  - iCache_need held high until ins_ready is seen.
  - flush_in=1: set discard flag; stay in MISS. The memory transaction cannot be aborted.
  - ins_ready=1 (this cycle):
    - Write data/tag and set valid at the latched index.
    - iCache_need<=0, ins_addr<=0, state<=IDLE, if_busy<=0.
    - If the discard flag is 0 and flush_in=0: if_valid<=1, if_ins<=ins, if_pc<=latched pc. Otherwise no response; clear the discard flag.
    - The line is filled even when discarded.
  - Dropping iCache_need on the ins_ready edge guarantees the controller, idle two cycles later, does not see a stale request.
- Fill overwrites whatever occupied the index (direct-mapped replacement).
- A fill and a hit lookup to the same index never coincide, since requests are ignored in MISS.
- Miss latency is controller-dependent. The cache adds one cycle for request and one for response.

Optional Feature:
- ICACHE_STATS_EN:
  - When defined, adds outputs hit_cnt[31:0] and miss_cnt[31:0].
  - Incremented on each accepted hit or miss (not flushed-cycle requests); wrap at 2^32.
  - Reset to 0; frozen when rdy_in=0.
- When undefined, these ports and counters do not exist. Functional behaviour is otherwise identical.

Test Plan:
- Reset then if_req, if_addr=0x0000_0010, memory holds 0x00A00093 -> iCache_need=1 with ins_addr=0x10. After ins_ready: if_valid pulse, if_ins=0x00A00093, if_pc=0x10. Re-request 0x10 -> if_valid next cycle, no iCache_need.
- Conflict: fetch 0x10 then 0x110 (same index, INDEX_BITS=6) -> both miss. Refetch 0x10 misses again.
- Flush in MISS for 0x20: assert flush_in while iCache_need=1 -> no if_valid on ins_ready. Line valid; later 0x20 hits in 1 cycle.
- flush_in and ins_ready same cycle -> no if_valid; line filled. flush_in with if_req in IDLE -> no response, no memory request.
- rdy_in low for 3 cycles during MISS with ins_ready high -> exactly one fill and one if_valid after rdy_in returns. Async reset mid-MISS -> iCache_need=0 immediately, all lines invalid.
- ICACHE_STATS_EN: 3 hits + 2 misses -> hit_cnt=3, miss_cnt=2.
